// File: rtl/sorted_array_streamer.sv
// Read side of the bubble-sort datapath: fetches the sorted array from a
// synchronous-read memory, lowest address first, onto a valid/ready stream.
module sorted_array_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_N = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH + 1)'(1);

  state_t state, state_next;

  logic [ADDR_WIDTH:0] n;
  logic [ADDR_WIDTH:0] idx;
  logic [ADDR_WIDTH:0] idx_inc;
  logic [ADDR_WIDTH:0] count_clamped;
  logic                at_last;
  logic                handshake;

  assign count_clamped = (count > MAX_N) ? MAX_N : count;
  assign idx_inc       = idx + ONE;
  assign at_last       = (idx == (n - ONE));
  assign handshake     = (state == ST_SEND) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (count_clamped != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SEND;
      ST_SEND: begin
        if (handshake) begin
          state_next = at_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state == ST_FETCH);
    out_valid = (state == ST_SEND);
    out_last  = (state == ST_SEND) && at_last;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
  end

  // mem_addr is loaded on the way into FETCH so it holds its value elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n        <= '0;
      idx      <= '0;
      mem_addr <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n        <= count_clamped;
            idx      <= '0;
            mem_addr <= '0;
          end
        end
        ST_LOAD: out_data <= mem_rd_data;
        ST_SEND: begin
          if (handshake && !at_last) begin
            idx      <= idx_inc;
            mem_addr <= idx_inc[ADDR_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_array_streamer.sv
// Scoreboard bench for sorted_array_streamer: directed runs push expected words
// into a queue, and a negedge monitor pops and compares on every handshake.
module tb_sorted_array_streamer;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  sorted_array_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] mem [DEPTH];
  int exp_words [DEPTH];

  int ready_mode = 0;
  int done_cnt = 0, done_cyc = 0, rd_cnt = 0, valid_cnt = 0, accepted = 0;
  int first_rd_cyc = -1, first_valid_cyc = -1, exp_addr = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: stability while stalled, address order, and scoreboard pops.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold)
        checkOutput("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_last, prev_data}));
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
        exp_addr++;
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        exp_t e;
        accepted++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0d expected none", out_data);
        end else begin
          e = q.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(e.data));
          checkOutput("out_last", 32'(out_last), 32'(e.last));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic applyStimulus(input int cnt, input int mode);
    int n, t, d0, rd0, v0, acc0, off;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = DW'(exp_words[i]);
      e.last = (i == n - 1);
      q.push_back(e);
    end
    d0 = done_cnt; rd0 = rd_cnt; v0 = valid_cnt; acc0 = accepted;
    first_rd_cyc = -1; first_valid_cyc = -1; exp_addr = 0;
    ready_mode = mode;
    @(negedge clk);
    start = 1'b1;
    count = (AW + 1)'(cnt);
    @(posedge clk);
    #1;
    t = cyc;
    start = 1'b0;
    count = (AW + 1)'(5);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != d0) break;
      @(posedge clk);
      #2;
    end
    checkOutput("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_once", 32'(done_cnt - d0), 32'd1);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("queue_empty", 32'(q.size()), 32'd0);
    checkOutput("word_count", 32'(accepted - acc0), 32'(n));
    if (n > 0) begin
      checkOutput("rd_latency", 32'(first_rd_cyc - t + 1), 32'd1);
      checkOutput("valid_latency", 32'(first_valid_cyc - t + 1), 32'd3);
      checkOutput("read_count", 32'(rd_cnt - rd0), 32'(n));
      if (mode == 0) checkOutput("done_latency", 32'(done_cyc - t + 1), 32'(3 * n + 1));
    end else begin
      off = done_cyc - t + 1;
      checkOutput("zero_done_latency", 32'(off >= 1 && off <= 2), 32'd1);
      checkOutput("zero_no_read", 32'(rd_cnt - rd0), 32'd0);
      checkOutput("zero_no_valid", 32'(valid_cnt - v0), 32'd0);
    end
    q.delete();
  endtask

  initial begin
    int d0, rd0, acc0;
    exp_t e;
    mem[0] = 16'd3;  mem[1] = 16'd5;  mem[2] = 16'd9;  mem[3] = 16'd12;
    mem[4] = 16'd20; mem[5] = 16'd21; mem[6] = 16'd30; mem[7] = 16'd40;
    exp_words = '{3, 5, 9, 12, 20, 21, 30, 40};
    rst = 1'b1; start = 1'b0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 32'({mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(8, 0);
    applyStimulus(3, 1);
    applyStimulus(0, 0);
    applyStimulus(12, 0);

    // Abandoned run: start re-pulse mid-run, then reset while word 2 is stalled.
    d0 = done_cnt; acc0 = accepted;
    first_rd_cyc = -1; first_valid_cyc = -1; exp_addr = 0;
    e.data = 16'd3; e.last = 1'b0;
    q.push_back(e);
    ready_mode = 0;
    @(negedge clk);
    start = 1'b1; count = 4'd8;
    @(negedge clk);
    start = 1'b0; count = 4'd5;
    for (int i = 0; i < 50; i++) begin
      if (accepted != acc0) break;
      @(negedge clk);
    end
    ready_mode = 2;
    start = 1'b1; count = 4'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    checkOutput("stall_word2", 32'(out_valid ? out_data : 16'hFFFF), 32'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset", 32'({mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd0 = rd_cnt;
    repeat (5) @(negedge clk);
    checkOutput("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    checkOutput("no_read_after_rst", 32'(rd_cnt - rd0), 32'd0);
    checkOutput("idle_after_rst", 32'(busy), 32'd0);
    checkOutput("word1_taken", 32'(q.size()), 32'd0);
    q.delete();

    applyStimulus(2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
